// File: rtl/lane_dual_port_ram.sv
// Simple dual-port RAM: multi-lane packed write port, single-word read port with
// RD_LAT (1|2) latency, and a one-word-per-cycle clear engine. Optional macro:
// LANE_RAM_RDW_BYPASS_EN enables write-first forwarding for same-cycle read/write.
module lane_dual_port_ram #(
  parameter int DW     = 16,
  parameter int AW     = 4,
  parameter int LANES  = 2,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [LANES-1:0]    wr_strb,
  input  logic [AW-1:0]       waddr,
  input  logic [LANES*DW-1:0] wdata,
  output logic                wr_drop,
  input  logic                rd_en,
  input  logic [AW-1:0]       raddr,
  output logic [DW-1:0]       rdata,
  output logic                rd_valid,
  input  logic                clr_req,
  output logic                clr_busy
);

  localparam int DEPTH = 1 << AW;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  if (LANES > DEPTH) begin : g_bad_lanes
    $error("lane_dual_port_ram: LANES (%0d) exceeds DEPTH (%0d)", LANES, DEPTH);
  end
  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
    $error("lane_dual_port_ram: RD_LAT must be 1 or 2, got %0d", RD_LAT);
  end

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          wr_drop_q, wr_drop_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] lane_addr [LANES];
  logic [AW-1:0] lane_off;
  logic          wr_ok;
  logic          rd_vld_q;
  logic [DW-1:0] rd_dat_q, rd_dat_d;

  assign clr_busy = (state_q == ST_CLEAR);
  assign wr_ok    = wr_en && (state_q == ST_IDLE);
  assign wr_drop  = wr_drop_q;
  assign wr_drop_d = wr_en && (|wr_strb) && (state_q == ST_CLEAR);

  // Each enabled lane lands at the base address plus the number of enabled lanes below it.
  always_comb begin
    lane_off = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_addr[k] = waddr + lane_off;
      if (wr_strb[k]) begin
        lane_off = lane_off + AW'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (state_q == ST_CLEAR) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_ok) begin
      for (int k = 0; k < LANES; k++) begin
        if (wr_strb[k]) begin
          mem_q[lane_addr[k]] <= wdata[k*DW +: DW];
        end
      end
    end
  end

  // Reads issued while clearing return zero regardless of how far the sweep has got.
  always_comb begin
    rd_dat_d = '0;
    if (rd_en && !clr_busy) begin
      rd_dat_d = mem_q[raddr];
`ifdef LANE_RAM_RDW_BYPASS_EN
      if (wr_ok) begin
        for (int k = 0; k < LANES; k++) begin
          if (wr_strb[k] && (lane_addr[k] == raddr)) begin
            rd_dat_d = wdata[k*DW +: DW];
          end
        end
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q <= 1'b0;
      rd_dat_q <= '0;
    end else begin
      rd_vld_q <= rd_en;
      rd_dat_q <= rd_dat_d;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic          rd_vld2_q;
    logic [DW-1:0] rd_dat2_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_vld2_q <= 1'b0;
        rd_dat2_q <= '0;
      end else begin
        rd_vld2_q <= rd_vld_q;
        rd_dat2_q <= rd_dat_q;
      end
    end

    assign rd_valid = rd_vld2_q;
    assign rdata    = rd_dat2_q;
  end else begin : g_lat1
    assign rd_valid = rd_vld_q;
    assign rdata    = rd_dat_q;
  end

endmodule

// File: tb/tb_lane_dual_port_ram.sv
// Bench for lane_dual_port_ram: drives one RD_LAT=1 and one RD_LAT=2 instance with
// identical stimulus and compares both against an array/queue reference model.
module tb_lane_dual_port_ram;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int LANES = 2;
  localparam int DEPTH = 1 << AW;
  localparam int WW    = LANES * DW;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wr_en;
  logic [LANES-1:0] wr_strb;
  logic [AW-1:0]    waddr;
  logic [WW-1:0]    wdata;
  logic             rd_en;
  logic [AW-1:0]    raddr;
  logic             clr_req;

  logic             wr_drop_l1, rd_valid_l1, clr_busy_l1;
  logic [DW-1:0]    rdata_l1;
  logic             wr_drop_l2, rd_valid_l2, clr_busy_l2;
  logic [DW-1:0]    rdata_l2;

  always #5 clk = ~clk;

  lane_dual_port_ram #(.DW(DW), .AW(AW), .LANES(LANES), .RD_LAT(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_strb(wr_strb), .waddr(waddr),
    .wdata(wdata), .wr_drop(wr_drop_l1), .rd_en(rd_en), .raddr(raddr),
    .rdata(rdata_l1), .rd_valid(rd_valid_l1), .clr_req(clr_req), .clr_busy(clr_busy_l1)
  );

  lane_dual_port_ram #(.DW(DW), .AW(AW), .LANES(LANES), .RD_LAT(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_strb(wr_strb), .waddr(waddr),
    .wdata(wdata), .wr_drop(wr_drop_l2), .rd_en(rd_en), .raddr(raddr),
    .rdata(rdata_l2), .rd_valid(rd_valid_l2), .clr_req(clr_req), .clr_busy(clr_busy_l2)
  );

  // Reference model state
  logic [DW-1:0] mem_m [DEPTH];
  int            busy_left;
  logic          p_vld;
  logic [DW-1:0] p_dat;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    busy_left = 0;
    p_vld     = 1'b0;
    p_dat     = '0;
  endtask

  task automatic idle_in();
    wr_en = 1'b0; wr_strb = '0; waddr = '0; wdata = '0;
    rd_en = 1'b0; raddr = '0; clr_req = 1'b0;
  endtask

  // One clock of the model on the currently driven inputs.
  task automatic model_cycle(output logic cv, output logic [DW-1:0] cd, output logic cdrop);
    logic [DW-1:0] words [$];
    bit busy;
    busy = (busy_left > 0);
    words = {};
    for (int k = 0; k < LANES; k++)
      if (wr_strb[k]) words.push_back(wdata[k*DW +: DW]);
    cv = rd_en;
    cd = '0;
    if (rd_en && !busy) begin
      cd = mem_m[raddr];
`ifdef LANE_RAM_RDW_BYPASS_EN
      if (wr_en)
        for (int i = 0; i < words.size(); i++)
          if (((int'(waddr) + i) % DEPTH) == int'(raddr)) cd = words[i];
`endif
    end
    cdrop = wr_en && (words.size() != 0) && busy;
    if (busy) begin
      busy_left--;
    end else begin
      if (wr_en)
        for (int i = 0; i < words.size(); i++)
          mem_m[(int'(waddr) + i) % DEPTH] = words[i];
      if (clr_req) begin
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        busy_left = DEPTH;
      end
    end
  endtask

  task automatic step();
    logic          cv, cdrop;
    logic [DW-1:0] cd;
    model_cycle(cv, cd, cdrop);
    @(posedge clk);
    #1;
    chk("l1_vld", 32'(rd_valid_l1), 32'(cv));
    chk("l1_dat", 32'(rdata_l1), 32'(cd));
    chk("l2_vld", 32'(rd_valid_l2), 32'(p_vld));
    chk("l2_dat", 32'(rdata_l2), 32'(p_dat));
    chk("l1_drop", 32'(wr_drop_l1), 32'(cdrop));
    chk("l2_drop", 32'(wr_drop_l2), 32'(cdrop));
    chk("l1_busy", 32'(clr_busy_l1), 32'(busy_left > 0));
    chk("l2_busy", 32'(clr_busy_l2), 32'(busy_left > 0));
    p_vld = cv;
    p_dat = cd;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_vld1"}, 32'(rd_valid_l1), 32'd0);
    chk({tag, "_vld2"}, 32'(rd_valid_l2), 32'd0);
    chk({tag, "_dat1"}, 32'(rdata_l1), 32'd0);
    chk({tag, "_dat2"}, 32'(rdata_l2), 32'd0);
    chk({tag, "_busy1"}, 32'(clr_busy_l1), 32'd0);
    chk({tag, "_busy2"}, 32'(clr_busy_l2), 32'd0);
    chk({tag, "_drop1"}, 32'(wr_drop_l1), 32'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic read_const(input logic [AW-1:0] a, input logic [DW-1:0] exp);
    idle_in();
    rd_en = 1'b1;
    raddr = a;
    step();
    chk("const_rd", 32'(rdata_l1), 32'(exp));
  endtask

  task automatic write_lanes(input logic [LANES-1:0] s, input logic [AW-1:0] a,
                             input logic [WW-1:0] d);
    idle_in();
    wr_en = 1'b1; wr_strb = s; waddr = a; wdata = d;
    step();
  endtask

  // Issues a clear and counts how many sampled cycles clr_busy stays high.
  task automatic run_clear(input bit poke_busy, output int busy_len);
    idle_in();
    clr_req = 1'b1;
    step();
    busy_len = clr_busy_l1 ? 1 : 0;
    for (int i = 0; i < DEPTH + 4; i++) begin
      idle_in();
      clr_req = (i == 2);
      if (poke_busy && i == 3) begin
        wr_en = 1'b1; wr_strb = 2'b11; waddr = 4'd7; wdata = 32'h1111_2222;
      end
      if (poke_busy && i == 5) begin
        rd_en = 1'b1; raddr = 4'd9;
      end
      step();
      if (poke_busy && i == 3) chk("busy_drop", 32'(wr_drop_l1), 32'd1);
      if (poke_busy && i == 4) chk("busy_drop_end", 32'(wr_drop_l1), 32'd0);
      if (poke_busy && i == 5) begin
        chk("busy_rd_vld", 32'(rd_valid_l1), 32'd1);
        chk("busy_rd_dat", 32'(rdata_l1), 32'd0);
      end
      if (clr_busy_l1) busy_len++;
    end
  endtask

  initial begin
    int blen;
    rst_n = 1'b0;
    idle_in();
    model_reset();
    #3;
    chk_reset_outputs("rst");
    release_reset();

    // Every word reads zero after reset.
    for (int a = 0; a < DEPTH; a++) begin
      read_const(AW'(a), '0);
      chk("rst_rd_vld", 32'(rd_valid_l1), 32'd1);
    end
    idle_in();
    step();

    // Wrap-around packing and strobe-skipped lanes.
    write_lanes(2'b11, 4'd15, 32'hBEEF_1234);
    write_lanes(2'b10, 4'd3, 32'hAAAA_5555);
    write_lanes(2'b00, 4'd8, 32'hDEAD_DEAD);
    read_const(4'd15, 16'h1234);
    read_const(4'd0, 16'hBEEF);
    read_const(4'd3, 16'hAAAA);
    read_const(4'd4, 16'h0000);
    read_const(4'd8, 16'h0000);

    // Back-to-back reads with a gap.
    for (int a = 0; a < 4; a++) begin
      idle_in(); rd_en = 1'b1; raddr = AW'(a); step();
    end
    idle_in(); step();
    idle_in(); rd_en = 1'b1; raddr = 4'd3; step();
    idle_in(); step();
    chk("lat2_tail", 32'(rdata_l2), 32'h0000_AAAA);

    // Same-cycle read and write of one address.
    idle_in();
    wr_en = 1'b1; wr_strb = 2'b01; waddr = 4'd5; wdata = 32'h0000_00AA;
    rd_en = 1'b1; raddr = 4'd5;
    step();
`ifdef LANE_RAM_RDW_BYPASS_EN
    chk("rdw_l1", 32'(rdata_l1), 32'h00AA);
`else
    chk("rdw_l1", 32'(rdata_l1), 32'h0000);
`endif
    idle_in(); step();
    read_const(4'd5, 16'h00AA);

    // Randomized traffic with occasional clears.
    for (int n = 0; n < 400; n++) begin
      idle_in();
      wr_en   = 1'($urandom_range(0, 1));
      wr_strb = LANES'($urandom);
      waddr   = AW'($urandom);
      wdata   = WW'({$urandom, $urandom});
      rd_en   = ($urandom_range(0, 3) != 0);
      raddr   = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom);
      clr_req = ($urandom_range(0, 49) == 0);
      step();
    end
    idle_in();
    for (int i = 0; i < DEPTH + 2; i++) step();

    // Fill, clear, poke during busy, then confirm everything reads zero.
    for (int a = 0; a < DEPTH; a += 2)
      write_lanes(2'b11, AW'(a), WW'({$urandom, $urandom}) | 32'h0001_0001);
    run_clear(1'b1, blen);
    chk("busy_len", 32'(blen), 32'(DEPTH));
    for (int a = 0; a < DEPTH; a++) read_const(AW'(a), '0);

    // Reset in the middle of a clear, then a full clear afterwards.
    for (int a = 0; a < DEPTH; a += 2)
      write_lanes(2'b11, AW'(a), 32'h5A5A_A5A5);
    idle_in(); clr_req = 1'b1; step();
    idle_in(); rd_en = 1'b1; raddr = 4'd2;
    for (int i = 0; i < 5; i++) step();
    rst_n = 1'b0;
    #1;
    chk("midclr_busy1", 32'(clr_busy_l1), 32'd0);
    chk("midclr_busy2", 32'(clr_busy_l2), 32'd0);
    chk("midclr_vld1", 32'(rd_valid_l1), 32'd0);
    chk("midclr_vld2", 32'(rd_valid_l2), 32'd0);
    idle_in();
    model_reset();
    @(posedge clk);
    release_reset();
    chk_reset_outputs("post_rst");
    write_lanes(2'b11, 4'd6, 32'h7777_6666);
    run_clear(1'b0, blen);
    chk("busy_len2", 32'(blen), 32'(DEPTH));
    read_const(4'd6, '0);
    read_const(4'd7, '0);
    idle_in(); step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lane_dual_port_ram.md
Name: lane_dual_port_ram

Overview:
Parametrised simple dual-port RAM with one write port and one read port. The write port takes LANES words per cycle with a per-lane strobe, and packs the enabled lanes into consecutive addresses. The read port has configurable latency and a valid flag. A built-in clear engine zeroes the whole array one word per cycle. Used as scratch/coefficient storage between datapath stages where a producer emits several words per beat and a consumer reads one word per beat.

Parameters:
DW, 16, data word width in bits
AW, 4, address width; DEPTH = 2**AW words
LANES, 2, words per write beat (1..8)
RD_LAT, 1, read latency in cycles; legal values 1 or 2

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
wr_en  in  1  write request this cycle
wr_strb  in  LANES  per-lane enable; bit k qualifies wdata lane k
waddr  in  AW  base write address
wdata  in  LANES*DW  lane k = wdata[k*DW +: DW]
wr_drop  out  1  one-cycle pulse: a write with non-zero strobe was discarded because clear is busy
rd_en  in  1  read request this cycle
raddr  in  AW  read address
rdata  out  DW  read data; 0 whenever rd_valid=0
rd_valid  out  1  rdata qualifier, RD_LAT cycles after rd_en
clr_req  in  1  start full-array clear (level-sampled, acts on rising cycle while IDLE)
clr_busy  out  1  high while clear engine runs

Behaviour:
- Reset (async): all DEPTH words = 0; rdata=0, rd_valid=0, wr_drop=0, clr_busy=0; clear FSM -> IDLE; read pipeline flushed.
- Write packing, on posedge when wr_en=1 and FSM is IDLE:
  - Enabled lanes are written in ascending lane order to addresses waddr, waddr+1, ...
  - Address arithmetic is modulo DEPTH, so wrap from DEPTH-1 to 0 is legal.
  - Lane k target = waddr + popcount(wr_strb[k-1:0]).
  - Disabled lanes neither consume an address nor alter memory.
  - wr_strb=0 is a no-op with no drop pulse.
  - LANES > DEPTH is illegal; flag it with a simulation-time error.
- Read, single-port behaviour:
  - rd_en sampled at cycle t; rdata/rd_valid presented at t+RD_LAT.
  - RD_LAT=2 adds one output register stage.
  - rd_en=0 gives rd_valid=0 and rdata=0 at the matching output cycle.
  - Back-to-back reads every cycle are supported; throughput 1 word/cycle.
- Read-during-write, same cycle and address: default returns the OLD word (see optional feature).
- Clear FSM:
  - States IDLE -> CLEAR -> IDLE.
  - IDLE: clr_req=1 -> CLEAR, with counter=0 and clr_busy=1 from the next cycle.
  - CLEAR: word[counter] <= 0 each cycle; counter++; after writing DEPTH-1 -> IDLE, clr_busy=0 next cycle. Total busy = DEPTH cycles.
  - clr_req during CLEAR is ignored (no restart).
  - Writes during CLEAR are discarded; wr_drop pulses in the same cycle's registered output (1 cycle later).
  - Reads issued while clr_busy=1 return rdata=0 with rd_valid=1 (deterministic, regardless of clear progress).
  - A write in the same cycle clr_req is accepted in IDLE is performed; clear starts the following cycle and wipes it.
  - rst_n assertion mid-CLEAR aborts to IDLE and zeros the array.
- Simultaneous read and write to different addresses are independent.

Optional Feature:
Macro LANE_RAM_RDW_BYPASS_EN.
- Defined: a read whose raddr matches any lane target address written in the same cycle returns the NEW lane data (write-first forwarding). With RD_LAT=2 the forwarded value travels through the extra stage unchanged. The clear rule still overrides: reads during clr_busy return 0.
- Undefined: read-first; the old word is returned. No forwarding logic is compiled.

Test Plan:
1. Reset then read all 16 addresses (defaults) -> rd_valid=1 after 1 cycle each, rdata=0x0000 for every address.
2. wr_en=1, strb=2'b11, waddr=15, wdata=0xBEEF_1234 -> mem[15]=0x1234, mem[0]=0xBEEF (wrap); strb=2'b10, waddr=3, wdata=0xAAAA_5555 -> mem[3]=0xAAAA, mem[4] unchanged.
3. RD_LAT=2: rd_en for 4 consecutive cycles, addresses 0..3 -> rd_valid high for 4 cycles starting 2 cycles after the first rd_en, data in order; rd_en gap -> rdata=0 in the matching slot.
4. Write 0x00AA to addr 5 and read addr 5 in the same cycle -> without macro rdata=old 0x0000; with LANE_RAM_RDW_BYPASS_EN rdata=0x00AA.
5. Fill memory, pulse clr_req -> clr_busy high exactly 16 cycles. A write during busy -> wr_drop=1 for 1 cycle, memory unchanged. A read during busy -> rdata=0, rd_valid=1. After busy, all words read 0.
6. Assert rst_n=0 at cycle 6 of a clear -> clr_busy=0, rd_valid=0 immediately. After release, a new clr_req is accepted and runs the full 16 cycles.
